perf_monitor: RTL and testbench

- Multi-channel performance monitor for the CPU sandbox. Successor to the single cycle counter with a fixed final PC.
- Counts CPU cycles plus N-1 external event streams between a start condition and program completion.
- Detects a hung CPU in addition to normal completion, and freezes all results.
- Exposes any counter nibble through a registered read port for the on-screen and 7-segment hex display logic.

---
 rtl/perf_pkg.sv | 23 ++
 rtl/perf_channel.sv | 28 ++
 rtl/perf_monitor.sv | 106 ++++++++++
 tb/tb_perf_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance monitor.
// Holds the FSM state encoding and the nibble extraction used by the readout path.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HUNG = 2'd3
  } perf_state_t;

  localparam int unsigned COUNT_WIDTH_DEFAULT = 32;
  localparam int unsigned DIGITS              = COUNT_WIDTH_DEFAULT / 4;
  localparam int unsigned NIBBLE_SRC_WIDTH    = 64;

  // Counters are zero-extended to NIBBLE_SRC_WIDTH before calling; digits past the end read 0.
  function automatic logic [3:0] nibble_of(input logic [NIBBLE_SRC_WIDTH-1:0] count,
                                           input int unsigned idx);
    if (idx >= NIBBLE_SRC_WIDTH / 4) return '0;
    return count[4*idx +: 4];
  endfunction

endpackage

// File: rtl/perf_channel.sv
// One saturating event counter with a sticky saturation flag.
// Never wraps: an increment attempted at all-ones leaves the count and sets sat.
module perf_channel #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   sat
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (en && inc) begin
      if (count == '1) sat <= 1'b1;
      else             count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Multi-channel performance monitor: cycle plus event counters between start and completion,
// with hang detection on a stalled PC and a registered nibble readout for the hex displays.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned PC_WIDTH     = 10,
  parameter int unsigned FINAL_PC     = 2**PC_WIDTH - 1,
  parameter int unsigned HANG_LIMIT   = 1024,
  parameter int unsigned AUTO_START   = 1
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic [PC_WIDTH-1:0]                pc,
  input  logic [NUM_CHANNELS-1:0]            ev,
  input  logic                               start,
  input  logic                               clear,
  input  logic [$clog2(NUM_CHANNELS)-1:0]    rd_ch,
  input  logic [$clog2(COUNT_WIDTH/4)-1:0]   rd_digit,
  output logic [3:0]                         rd_nibble,
  output logic [1:0]                         state,
  output logic                               running,
  output logic                               finished,
  output logic                               hung,
  output logic [NUM_CHANNELS-1:0]            saturated
);

  localparam int unsigned HANG_W   = (HANG_LIMIT > 1) ? $clog2(HANG_LIMIT) : 1;
  localparam int unsigned HANG_MAX = (HANG_LIMIT > 0) ? HANG_LIMIT - 1 : 0;

  perf_state_t             state_q, state_n;
  logic [HANG_W-1:0]       hang_q, hang_n;
  logic [PC_WIDTH-1:0]     pc_prev;
  logic [COUNT_WIDTH-1:0]  counts [NUM_CHANNELS];
  logic [3:0]              rd_next;
  logic                    pc_same, pc_final;
  logic                    unused_ev0;

  // Channel 0 counts cycles, so its event strobe is not used.
  assign unused_ev0 = ev[0];

  assign pc_same  = (pc == pc_prev);
  assign pc_final = (pc == PC_WIDTH'(FINAL_PC));

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    perf_channel #(.COUNT_WIDTH(COUNT_WIDTH)) u_ch (
      .clk    (clk),
      .resetN (resetN),
      .clr    (clear),
      .en     (state_q == RUN),
      .inc    ((k == 0) ? 1'b1 : ev[k]),
      .count  (counts[k]),
      .sat    (saturated[k])
    );
  end

  always_comb begin
    state_n = state_q;
    hang_n  = hang_q;
    if (clear) begin
      state_n = IDLE;
      hang_n  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          hang_n = '0;
          if (AUTO_START != 0 || start) state_n = RUN;
        end
        RUN: begin
          hang_n = pc_same ? hang_q + HANG_W'(1) : '0;
          // Completion is checked last so it overrides a hang on the same edge.
          if (HANG_LIMIT != 0 && pc_same && hang_q == HANG_W'(HANG_MAX)) state_n = HUNG;
          if (pc_final) state_n = DONE;
        end
        default: hang_n = '0;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    if (NUM_CHANNELS > 32'(rd_ch))
      rd_next = nibble_of(NIBBLE_SRC_WIDTH'(counts[rd_ch]), 32'(rd_digit));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      hang_q    <= '0;
      pc_prev   <= '0;
      rd_nibble <= '0;
    end else begin
      state_q   <= state_n;
      hang_q    <= hang_n;
      pc_prev   <= pc;
      rd_nibble <= rd_next;
    end
  end

  assign state    = state_q;
  assign running  = (state_q == RUN);
  assign finished = (state_q == DONE) || (state_q == HUNG);
  assign hung     = (state_q == HUNG);

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: two configurations driven by shared stimulus, each checked every
// cycle against an arithmetic model, plus directed spec-value checks and randomized traffic.
module tb_perf_monitor;
  import perf_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic [9:0] pc;
  logic [3:0] ev;
  logic       start, clear;
  logic [1:0] rd_ch;
  logic [2:0] rd_digit_a;
  logic [0:0] rd_digit_b;

  logic [3:0] nib_a, nib_b;
  logic [1:0] state_a, state_b;
  logic       running_a, running_b, finished_a, finished_b, hung_a, hung_b;
  logic [2:0] sat_a;
  logic [3:0] sat_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_monitor #(.NUM_CHANNELS(3), .COUNT_WIDTH(32), .PC_WIDTH(10), .FINAL_PC(10),
                 .HANG_LIMIT(8), .AUTO_START(1)) ua (
    .clk(clk), .resetN(resetN), .pc(pc), .ev(ev[2:0]), .start(start), .clear(clear),
    .rd_ch(rd_ch), .rd_digit(rd_digit_a), .rd_nibble(nib_a), .state(state_a),
    .running(running_a), .finished(finished_a), .hung(hung_a), .saturated(sat_a));

  perf_monitor #(.NUM_CHANNELS(4), .COUNT_WIDTH(8), .PC_WIDTH(10), .FINAL_PC(1000),
                 .HANG_LIMIT(0), .AUTO_START(0)) ub (
    .clk(clk), .resetN(resetN), .pc(pc), .ev(ev), .start(start), .clear(clear),
    .rd_ch(rd_ch), .rd_digit(rd_digit_b), .rd_nibble(nib_b), .state(state_b),
    .running(running_b), .finished(finished_b), .hung(hung_b), .saturated(sat_b));

  // Reference model: 0=IDLE 1=RUN 2=DONE 3=HUNG; m_run = consecutive unchanged-PC samples in RUN.
  int cfg_nch[2]  = '{3, 4};
  int cfg_cw[2]   = '{32, 8};
  int cfg_fpc[2]  = '{10, 1000};
  int cfg_hl[2]   = '{8, 0};
  int cfg_auto[2] = '{1, 0};

  int              m_st[2];
  longint unsigned m_cnt[2][4];
  bit              m_sat[2][4];
  int              m_run[2];
  int              m_pcprev[2];
  int              m_rd[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_run[d] = 0; m_pcprev[d] = 0; m_rd[d] = 0;
      for (int k = 0; k < 4; k++) begin m_cnt[d][k] = 0; m_sat[d][k] = 0; end
    end
  endtask

  task automatic model_step(input int d);
    int nch;
    longint unsigned maxv;
    int dig;
    bit unch;
    nch  = cfg_nch[d];
    maxv = (64'd1 << cfg_cw[d]) - 64'd1;
    dig  = (d == 0) ? int'(rd_digit_a) : int'(rd_digit_b);
    unch = (int'(pc) == m_pcprev[d]);
    m_rd[d] = (int'(rd_ch) < nch) ? int'((m_cnt[d][rd_ch] >> (4 * dig)) & 64'hF) : 0;
    if (clear) begin
      m_st[d] = 0; m_run[d] = 0;
      for (int k = 0; k < 4; k++) begin m_cnt[d][k] = 0; m_sat[d][k] = 0; end
    end else if (m_st[d] == 0) begin
      m_run[d] = 0;
      if (cfg_auto[d] != 0 || start) m_st[d] = 1;
    end else if (m_st[d] == 1) begin
      for (int k = 0; k < nch; k++)
        if (k == 0 || ev[k]) begin
          if (m_cnt[d][k] == maxv) m_sat[d][k] = 1;
          else m_cnt[d][k] = m_cnt[d][k] + 1;
        end
      m_run[d] = unch ? m_run[d] + 1 : 0;
      if (int'(pc) == cfg_fpc[d]) m_st[d] = 2;
      else if (cfg_hl[d] > 0 && m_run[d] >= cfg_hl[d]) m_st[d] = 3;
    end
    m_pcprev[d] = int'(pc);
  endtask

  function automatic int exp_sat(input int d);
    int v = 0;
    for (int k = 0; k < cfg_nch[d]; k++) if (m_sat[d][k]) v |= (1 << k);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.state", 32'(state_a), m_st[0]);
    chk("a.running", 32'(running_a), 32'(m_st[0] == 1));
    chk("a.finished", 32'(finished_a), 32'(m_st[0] >= 2));
    chk("a.hung", 32'(hung_a), 32'(m_st[0] == 3));
    chk("a.saturated", 32'(sat_a), exp_sat(0));
    chk("a.rd_nibble", 32'(nib_a), m_rd[0]);
    chk("b.state", 32'(state_b), m_st[1]);
    chk("b.running", 32'(running_b), 32'(m_st[1] == 1));
    chk("b.finished", 32'(finished_b), 32'(m_st[1] >= 2));
    chk("b.hung", 32'(hung_b), 32'(m_st[1] == 3));
    chk("b.saturated", 32'(sat_b), exp_sat(1));
    chk("b.rd_nibble", 32'(nib_b), m_rd[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (resetN) begin model_step(0); model_step(1); end
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic read_both(input logic [1:0] ch, output longint unsigned a, output longint unsigned b);
    a = 0; b = 0;
    rd_ch = ch;
    for (int dig = 0; dig < 8; dig++) begin
      rd_digit_a = 3'(dig);
      rd_digit_b = 1'(dig);
      cycle();
      a |= longint'(nib_a) << (4 * dig);
      if (dig < 2) b |= longint'(nib_b) << (4 * dig);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  initial begin
    longint unsigned va, vb;
    resetN = 1'b1; pc = '0; ev = '0; start = 1'b0; clear = 1'b0;
    rd_ch = '0; rd_digit_a = '0; rd_digit_b = '0;
    model_reset();
    #1 resetN = 1'b0;
    repeat (2) cycle();
    chk("reset.state_a", 32'(state_a), 32'(IDLE));
    chk("reset.nib_a", 32'(nib_a), 0);
    resetN = 1'b1;

    // Normal completion at FINAL_PC=10 with pc stepping 0..10.
    cycle();
    chk("t1.enter_run", 32'(running_a), 1);
    for (int p = 0; p <= 10; p++) begin pc = 10'(p); cycle(); end
    chk("t1.done", 32'(state_a), 32'(DONE));
    chk("t1.finished", 32'(finished_a), 1);
    chk("t1.not_hung", 32'(hung_a), 0);
    pc = 10'd3;
    repeat (3) cycle();
    read_both(2'd0, va, vb);
    chk("t1.ch0", 32'(va), 11);

    // Hang after exactly 8 unchanged samples.
    do_clear();
    pc = 10'd5; cycle();
    repeat (7) cycle();
    chk("t2.still_run", 32'(running_a), 1);
    cycle();
    chk("t2.hung", 32'(hung_a), 1);
    chk("t2.finished", 32'(finished_a), 1);

    // PC change on sample 7 restarts the hang count.
    do_clear();
    cycle();
    repeat (6) cycle();
    pc = 10'd6; cycle();
    repeat (7) cycle();
    chk("t2b.no_hang", 32'(running_a), 1);
    pc = 10'd10; cycle();
    chk("t2b.done", 32'(state_a), 32'(DONE));

    // Event counting: ev[1] every other cycle over 20 RUN cycles.
    do_clear();
    pc = 10'd100; cycle();
    for (int i = 0; i < 20; i++) begin
      pc = 10'(200 + i);
      ev = {1'($urandom), 1'b0, 1'(i % 2 == 0), 1'($urandom)};
      cycle();
    end
    ev = '0; pc = 10'd10; cycle();
    ev = 4'hF; repeat (5) cycle(); ev = '0;
    read_both(2'd0, va, vb); chk("t3.ch0", 32'(va), 21);
    read_both(2'd1, va, vb); chk("t3.ch1", 32'(va), 10);
    read_both(2'd2, va, vb); chk("t3.ch2", 32'(va), 0);

    // 8-bit saturation in the AUTO_START=0 instance.
    start = 1'b1; cycle(); start = 1'b0;
    chk("t4.b_run", 32'(running_b), 1);
    for (int i = 0; i < 300; i++) begin
      pc = 10'($urandom_range(0, 999));
      ev = {1'($urandom), 1'b0, 1'b1, 1'($urandom)};
      cycle();
    end
    chk("t4.sat0", 32'(sat_b[0]), 1);
    chk("t4.sat1", 32'(sat_b[1]), 1);
    chk("t4.sat2", 32'(sat_b[2]), 0);
    pc = 10'd1000; ev = '0; cycle();
    chk("t4.b_done", 32'(state_b), 32'(DONE));
    read_both(2'd1, va, vb); chk("t4.b_ch1", 32'(vb), 32'hFF);
    read_both(2'd0, va, vb); chk("t4.b_ch0", 32'(vb), 32'hFF);

    // Channel 0 = 0x1234 at DONE, then nibble readout and out-of-range channel.
    do_clear();
    pc = 10'd11; cycle();
    for (int i = 0; i < 32'h1233; i++) begin pc = 10'(11 + (i % 900)); cycle(); end
    pc = 10'd10; cycle();
    rd_ch = 2'd0; rd_digit_a = 3'd2; cycle();
    chk("t5.digit2", 32'(nib_a), 2);
    rd_digit_a = 3'd1; cycle();
    chk("t5.digit1", 32'(nib_a), 3);
    rd_ch = 2'd3; cycle();
    chk("t5.bad_ch", 32'(nib_a), 0);

    // clear together with FINAL_PC wins and zeroes the counters.
    do_clear();
    pc = 10'd50; cycle();
    for (int i = 0; i < 5; i++) begin pc = 10'(60 + i); cycle(); end
    rd_ch = 2'd0; rd_digit_a = 3'd0;
    pc = 10'd10; clear = 1'b1; cycle(); clear = 1'b0;
    chk("t6.idle", 32'(state_a), 32'(IDLE));
    pc = 10'd70; cycle();
    chk("t6.rerun", 32'(running_a), 1);
    chk("t6.zeroed", 32'(nib_a), 0);

    // Asynchronous reset mid-RUN.
    for (int i = 0; i < 3; i++) begin pc = 10'(80 + i); cycle(); end
    #2 resetN = 1'b0;
    #1 model_reset();
    check_all();
    chk("t7.async_state", 32'(state_a), 32'(IDLE));
    chk("t7.async_nib", 32'(nib_a), 0);
    cycle();
    resetN = 1'b1;

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      pc    = ($urandom_range(0, 9) == 0) ? 10'd1000 : 10'($urandom_range(0, 15));
      ev    = 4'($urandom);
      start = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 30) == 0);
      rd_ch = 2'($urandom);
      rd_digit_a = 3'($urandom);
      rd_digit_b = 1'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
